// File: rtl/mix_pkg.sv
// Shared GF(2^8) arithmetic, FSM state encoding and column width for the
// MixColumns engine.
package mix_pkg;

    localparam int COL_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in
// the most significant byte).
module mix_col_unit
    import mix_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [COL_W-1:0] col,
    input  logic             inv,
    output logic [COL_W-1:0] mixed
);

    logic [7:0]       a [4];
    logic [COL_W-1:0] fwd;

    always_comb begin
        fwd = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = col[COL_W-1-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            fwd[COL_W-1-8*i -: 8] = gf_mul2(a[i]) ^ gf_mul3(a[(i+1)%4])
                                  ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
    end

    // The inverse datapath only exists when the build asks for it.
    if (INV_EN != 0) begin : g_inv
        logic [COL_W-1:0] rev;

        always_comb begin
            rev = '0;
            for (int i = 0; i < 4; i++) begin
                rev[COL_W-1-8*i -: 8] = gf_mul14(a[i]) ^ gf_mul11(a[(i+1)%4])
                                      ^ gf_mul13(a[(i+2)%4]) ^ gf_mul9(a[(i+3)%4]);
            end
        end

        assign mixed = inv ? rev : fwd;
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        assign mixed      = fwd;
    end

endmodule

// File: rtl/mix_columns_engine.sv
// AES MixColumns engine: accepts a 128-bit state, transforms COLS_PER_CYC
// columns per clock in place, then holds the result until it is taken.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | in_ready high, waiting for in_valid to capture a block
//   CALC    | transforming columns, lowest index first
//   DONE    | out_valid high, result held until out_ready
module mix_columns_engine
    import mix_pkg::*;
#(
    parameter int COLS_PER_CYC = 1,
    parameter int INV_EN       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYC must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYC);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYC);
    localparam logic       INV_BIT  = (INV_EN != 0);

    mix_state_e   fsm_q;
    logic [127:0] st_q;
    logic [127:0] st_calc;
    logic [1:0]   cnt_q;
    logic         mode_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [COL_W-1:0] col_in  [COLS_PER_CYC];
    logic [COL_W-1:0] col_out [COLS_PER_CYC];

    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
        assign col_in[g] = st_q[127 - COL_W*(int'(cnt_q) + g) -: COL_W];

        mix_col_unit #(.INV_EN(INV_EN)) u_col (
            .col   (col_in[g]),
            .inv   (mode_q),
            .mixed (col_out[g])
        );
    end

    always_comb begin
        st_calc = st_q;
        for (int g = 0; g < COLS_PER_CYC; g++) begin
            st_calc[127 - COL_W*(int'(cnt_q) + g) -: COL_W] = col_out[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            st_q        <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_q       <= in_data;
                        mode_q     <= in_inv & INV_BIT;
                        cnt_q      <= '0;
                        fsm_q      <= ST_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    st_q  <= st_calc;
                    cnt_q <= cnt_q + STEP;
                    if (cnt_q == LAST_COL) begin
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_valid_q ? st_q : '0;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine: four builds (1, 2, 4 columns per
// cycle, and forward-only) checked for data, latency, backpressure and reset.
module tb_mix_columns_engine;

    localparam int ND = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [127:0] in_data   [ND];
    logic         in_inv    [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] out_data  [ND];
    logic         busy      [ND];

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q [$];

    localparam int LAT [ND] = '{5, 3, 2, 5};

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        mix_columns_engine #(
            .COLS_PER_CYC (d == 1 ? 2 : (d == 2 ? 4 : 1)),
            .INV_EN       (d == 3 ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[d]),
            .in_ready  (in_ready[d]),
            .in_data   (in_data[d]),
            .in_inv    (in_inv[d]),
            .out_valid (out_valid[d]),
            .out_ready (out_ready[d]),
            .out_data  (out_data[d]),
            .busy      (busy[d])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
        logic [127:0] r = '0;
        logic [7:0] a [4];
        logic [7:0] k [4];
        logic [7:0] b;
        if (inv) begin k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9; end
        else     begin k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1; end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(a[(i+j)%4], k[j]);
                r[127 - 32*c - 8*i -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic send(input int d, input logic [127:0] data, input logic inv,
                        input logic [127:0] exp);
        int t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready dut%0d: in_ready=%b, want 1", d, in_ready[d]);
        end
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_inv[d]   = inv;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]   = ~inv;
    endtask

    task automatic recv(input int d, input int stall);
        int lat;
        int bad;
        logic [127:0] exp;
        @(negedge clk);
        lat = 1;
        while (!out_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (out_valid[d] !== 1'b1 || lat != LAT[d]) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d cycles (out_valid=%b), want %0d",
                     d, lat, out_valid[d], LAT[d]);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_tests++;
        if (out_data[d] !== exp || busy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL data dut%0d: got %h busy=%b, want %h busy=1", d, out_data[d], busy[d], exp);
        end
        if (stall > 0) begin
            bad = 0;
            out_ready[d] = 1'b0;
            for (int i = 0; i < stall; i++) begin
                in_valid[d] = i[0];
                in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                if (out_valid[d] !== 1'b1 || out_data[d] !== exp || in_ready[d] !== 1'b0) bad++;
            end
            in_valid[d] = 1'b0;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL stall_hold dut%0d: %0d bad cycles, want 0", d, bad);
            end
            out_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0 || out_data[d] !== '0) begin
            n_fail++;
            $display("FAIL release dut%0d: out_valid=%b in_ready=%b busy=%b out_data=%h, want 0 1 0 0",
                     d, out_valid[d], in_ready[d], busy[d], out_data[d]);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== '0 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 0 0",
                         tag, d, in_ready[d], out_valid[d], out_data[d], busy[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_idle("reset_assert");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_release");
    endtask

    task automatic test_forward();
        send(0, {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        recv(0, 0);
        send(0, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0,
                {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6});
        recv(0, 0);
    endtask

    task automatic test_inverse();
        send(0, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8}, 1'b1,
                {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c});
        recv(0, 0);
    endtask

    task automatic test_sweep();
        for (int d = 1; d <= 2; d++) begin
            send(d, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0,
                    {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6});
            recv(d, 0);
            send(d, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8}, 1'b1,
                    {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c});
            recv(d, 0);
        end
    endtask

    task automatic test_inv_disabled();
        send(3, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b1,
                {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6});
        recv(3, 0);
    endtask

    task automatic test_backpressure();
        send(0, {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        recv(0, 10);
    endtask

    task automatic test_back_to_back();
        logic [127:0] s;
        logic inv;
        for (int n = 0; n < 6; n++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = n[0];
            for (int d = 0; d < ND; d++) begin
                send(d, s, inv, mix_model(s, inv & (d != 3)));
                recv(d, 0);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen = 0;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = {4{32'hdb135345}};
        in_inv[0]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("reset_mid_calc");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0 || out_data[0] !== '0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_output: %0d cycles with output, want 0", seen);
        end
        send(0, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0,
                {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6});
        recv(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_inv[d]    = 1'b0;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_forward();
        test_inverse();
        test_sweep();
        test_inv_disabled();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL provide parameter COLS_PER_CYC, default 1, meaning AES columns processed per clock; legal values 1, 2, 4.
REQ-002 SHALL provide parameter INV_EN, default 1, meaning 1 = forward and InvMixColumns supported, 0 = forward only.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, in_data/in_inv valid.
REQ-007 SHALL have port in_ready, output, 1, engine accepts a block.
REQ-008 SHALL have port in_data, input, 128, AES state; column c = bits [127-32c -: 32], row 0 byte most significant.
REQ-009 SHALL have port in_inv, input, 1, 1 = InvMixColumns for this block.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a finished result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_data, output, 128, transformed state, same column layout as in_data.
REQ-013 SHALL have port busy, output, 1, high in CALC and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: in_ready=1; on in_valid, capture in_data into the state register, latch mode (in_inv AND INV_EN), clear column counter, go to CALC.
REQ-016 CALC: each cycle transform COLS_PER_CYC columns in place, lowest column index first; counter advances by COLS_PER_CYC.
REQ-017 Leave CALC for DONE in the cycle the last column (index 3) is written; CALC lasts exactly 4/COLS_PER_CYC cycles.
REQ-018 Latency: out_valid SHALL assert 4/COLS_PER_CYC + 1 cycles after the accepting edge (COLS_PER_CYC=1: 5 cycles).
REQ-019 Forward column (a0..a3): b_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4, GF(2^8) polynomial 0x11B.
REQ-020 Inverse column: b_i = 14*a_i ^ 11*a_(i+1) ^ 13*a_(i+2) ^ 9*a_(i+3), same field.
REQ-021 DONE: out_valid=1, out_data=state register, stable while out_ready=0; when out_ready=1, return to IDLE next cycle.
REQ-022 in_ready SHALL be 0 in CALC and DONE; in_valid ignored there; no input accepted in the same cycle as an output transfer.
REQ-023 in_inv SHALL be sampled only at acceptance; later changes have no effect on the block in flight.
REQ-024 INV_EN=0: in_inv ignored, inverse multipliers absent from netlist.
REQ-025 COLS_PER_CYC outside {1,2,4} SHALL cause an elaboration error.
REQ-026 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, state register 0, mode 0.
REQ-028 Reset values: in_ready=1 after release, out_valid=0, out_data=0, busy=0.
REQ-029 Reset during CALC or DONE SHALL abort the block; no out_valid for it after release.

Structure
REQ-030 Shared package mix_pkg SHALL hold: xtime function, gf_mul2/3/9/11/13/14 functions, FSM state enum, column-width constant COL_W=32.
REQ-031 SHALL instantiate COLS_PER_CYC copies of sub-module mix_col_unit (32-bit column in, 32-bit out, inv input, combinational, parameter INV_EN).
REQ-032 Only the state register, counter, mode bit and FSM SHALL be sequential.

Verification
REQ-033 Forward, COLS_PER_CYC=1: column db135345 in all four positions -> every column 8e4da1bc, out_valid at cycle 5.
REQ-034 Forward: columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5 -> 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6.
REQ-035 Inverse: columns 8e4da1bc, 9fdc589d, 01010101, 4d7ebdf8 -> db135345, f20a225c, 01010101, 2d26314c.
REQ-036 Backpressure: out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-CALC (cycle 2) -> out_valid never asserts, out_data=0, next block processes correctly.
REQ-038 Sweep COLS_PER_CYC=2 and 4 with REQ-034 vectors -> identical results, latencies 3 and 2 cycles.
